// File: rtl/mul_issue_wb_if.sv
// Shared opcode type and the three handshake channels of mul_issue_wb:
// execute-side request, multiplier issue/result, and register-file writeback.
package mul_issue_wb_pkg;
  typedef enum logic [2:0] {
    MUL_NONE   = 3'd0,
    MUL_MUL    = 3'd1,
    MUL_MULH   = 3'd2,
    MUL_MULHSU = 3'd3,
    MUL_MULHU  = 3'd4
  } riscv_mul_op_e;
endpackage

interface mul_req_if;
  logic        valid;
  logic        ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  modport master (output valid, funct3, rs1, rs2, rd, input ready);
  modport slave  (input valid, funct3, rs1, rs2, rd, output ready);
endinterface

interface mul_core_if;
  import mul_issue_wb_pkg::*;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  riscv_mul_op_e in_op;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  modport master (output in_valid, in_a, in_b, in_op, out_ready,
                  input in_ready, out_valid, out_result);
  modport slave  (input in_valid, in_a, in_b, in_op, out_ready,
                  output in_ready, out_valid, out_result);
endinterface

interface mul_wb_if;
  logic        valid;
  logic        ready;
  logic [4:0]  rd;
  logic        we;
  logic [31:0] data;
  modport master (output valid, rd, we, data, input ready);
  modport slave  (input valid, rd, we, data, output ready);
endinterface

// File: rtl/mul_issue_wb.sv
// Issue/writeback wrapper around the sequential multiplier: issue register, in-order tag FIFO,
// registered writeback. Optional zero-operand shortcut enabled by `define MUL_ZERO_BYPASS_EN.
module mul_issue_wb
  import mul_issue_wb_pkg::*;
#(
  parameter int TAG_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  mul_req_if.slave   req,
  mul_core_if.master mul,
  mul_wb_if.master   wb,
  output logic       busy_o
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
  } tag_t;

  typedef struct packed {
    logic [31:0]   a;
    logic [31:0]   b;
    riscv_mul_op_e op;
  } iss_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } wb_t;

  logic             iss_vld_q, iss_vld_d;
  iss_t             iss_q, iss_d;
  tag_t             tag_q [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wb_vld_q, wb_vld_d;
  wb_t              wb_q, wb_d;

  logic iss_free, tag_full, tag_empty, wb_free;
  logic accept, byp_elig, byp, push, res_hs, pop;
  tag_t tag_head;

  function automatic riscv_mul_op_e f3_to_op(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return MUL_MUL;
      2'd1:    return MUL_MULH;
      2'd2:    return MUL_MULHSU;
      default: return MUL_MULHU;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign iss_free  = !iss_vld_q || mul.in_ready;
  assign tag_full  = (cnt_q == CNT_W'(TAG_DEPTH));
  assign tag_empty = (cnt_q == '0);
  assign wb_free   = !wb_vld_q || wb.ready;

  // Readiness ignores a same-cycle pop so mul_out_valid never reaches req_ready.
  assign req.ready = iss_free && !tag_full;
  assign accept    = req.valid && req.ready;

`ifdef MUL_ZERO_BYPASS_EN
  // Only with nothing ahead of it can a zero product skip the multiplier and stay in order.
  assign byp_elig = ((req.rs1 == '0) || (req.rs2 == '0)) && tag_empty && !iss_vld_q && wb_free;
`else
  assign byp_elig = 1'b0;
`endif

  assign byp  = accept && byp_elig;
  assign push = accept && !byp_elig;

  assign mul.out_ready = wb_free;
  assign res_hs        = mul.out_valid && mul.out_ready;
  // An orphan result is consumed but dropped; it never reaches writeback.
  assign pop           = res_hs && !tag_empty;
  assign tag_head      = tag_q[rd_ptr_q];

  always_comb begin
    iss_vld_d = iss_vld_q;
    iss_d     = iss_q;
    if (push) begin
      iss_vld_d = 1'b1;
      iss_d     = '{a: req.rs1, b: req.rs2, op: f3_to_op(req.funct3)};
    end else if (mul.in_ready) begin
      iss_vld_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    wb_vld_d = wb_vld_q;
    wb_d     = wb_q;
    if (pop) begin
      wb_vld_d = 1'b1;
      wb_d     = '{rd: tag_head.rd, we: tag_head.we, data: mul.out_result};
    end else if (byp) begin
      wb_vld_d = 1'b1;
      wb_d     = '{rd: req.rd, we: (req.rd != '0), data: '0};
    end else if (wb.ready) begin
      wb_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld_q <= 1'b0;
      iss_q     <= '{a: '0, b: '0, op: MUL_NONE};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      wb_vld_q  <= 1'b0;
      wb_q      <= '0;
    end else begin
      iss_vld_q <= iss_vld_d;
      iss_q     <= iss_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      wb_vld_q  <= wb_vld_d;
      wb_q      <= wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= '{rd: req.rd, we: (req.rd != '0)};
  end

  assign mul.in_valid = iss_vld_q;
  assign mul.in_a     = iss_q.a;
  assign mul.in_b     = iss_q.b;
  assign mul.in_op    = iss_q.op;

  assign wb.valid = wb_vld_q;
  assign wb.rd    = wb_q.rd;
  assign wb.we    = wb_q.we;
  assign wb.data  = wb_q.data;

  assign busy_o = iss_vld_q || !tag_empty || wb_vld_q;

  a_funct3_legal: assert property (@(posedge clk) disable iff (rst) accept |-> !req.funct3[2]);
  a_no_orphan:    assert property (@(posedge clk) disable iff (rst) res_hs |-> !tag_empty);

endmodule

// File: tb/tb_mul_issue_wb.sv
// Randomized bench for mul_issue_wb: a behavioural multiplier drives the core side and an
// expected-record queue built from request arithmetic checks every writeback in order.
module tb_mul_issue_wb;
  import mul_issue_wb_pkg::*;

  localparam int TAG_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  mul_req_if  req_if ();
  mul_core_if mul_if ();
  mul_wb_if   wb_if  ();

  mul_issue_wb #(.TAG_DEPTH(TAG_DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req_if),
    .mul   (mul_if),
    .wb    (wb_if),
    .busy_o(busy)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } rec_t;

  typedef struct {
    logic [31:0] res;
    int          due;
  } mres_t;

  rec_t  exp_q[$];
  mres_t mq[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_iss = 0, n_wb = 0, n_acc = 0;
  int mul_rdy_pct = 100, mul_max_dly = 0, wb_mode = 1;
  bit mclr = 1'b0;

  logic [31:0]   last_data;
  logic [4:0]    last_rd;
  logic          last_we;
  riscv_mul_op_e last_op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural M-extension products from 64-bit arithmetic.
  function automatic logic [31:0] ref_mul(input int f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      0: begin p = sa * sb; return p[31:0]; end
      1: begin p = sa * sb; return p[63:32]; end
      2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic int op_to_f(input riscv_mul_op_e op);
    case (op)
      MUL_MUL:    return 0;
      MUL_MULH:   return 1;
      MUL_MULHSU: return 2;
      MUL_MULHU:  return 3;
      default:    return 7;
    endcase
  endfunction

  // Behavioural multiplier: random accept, random latency, in-order results held until taken.
  initial begin
    mul_if.in_ready   = 1'b0;
    mul_if.out_valid  = 1'b0;
    mul_if.out_result = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mclr) begin mul_if.out_valid = 1'b0; mclr = 1'b0; end
      mul_if.in_ready = ($urandom_range(99) < mul_rdy_pct);
      if (!mul_if.out_valid && mq.size() > 0 && mq[0].due <= cyc) begin
        mul_if.out_valid  = 1'b1;
        mul_if.out_result = mq[0].res;
      end
      #4;
      if (rst) begin
        mq.delete();
        mclr = 1'b1;
      end else begin
        if (mul_if.in_valid && mul_if.in_ready) begin
          mq.push_back(mres_t'{res: ref_mul(op_to_f(mul_if.in_op), mul_if.in_a, mul_if.in_b),
                               due: cyc + 1 + int'($urandom_range(mul_max_dly))});
          last_op = mul_if.in_op;
          n_iss++;
        end
        if (mul_if.out_valid && mul_if.out_ready) begin
          void'(mq.pop_front());
          mclr = 1'b1;
        end
      end
    end
  end

  initial begin
    wb_if.ready = 1'b1;
    forever begin
      @(negedge clk);
      case (wb_mode)
        0:       wb_if.ready = 1'b0;
        1:       wb_if.ready = 1'b1;
        default: wb_if.ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Writeback scoreboard plus payload-stability checks on both stalled outputs.
  initial begin
    bit            wb_held = 1'b0, mi_held = 1'b0;
    logic [31:0]   h_data, h_a, h_b;
    logic [5:0]    h_rdwe;
    riscv_mul_op_e h_op;
    rec_t          e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        wb_held = 1'b0;
        mi_held = 1'b0;
      end else begin
        if (wb_held) begin
          chk("wb_hold_vld", 32'(wb_if.valid), 32'd1);
          chk("wb_hold_data", wb_if.data, h_data);
          chk("wb_hold_rdwe", 32'({wb_if.rd, wb_if.we}), 32'(h_rdwe));
        end
        if (mi_held) begin
          chk("mi_hold_vld", 32'(mul_if.in_valid), 32'd1);
          chk("mi_hold_a", mul_if.in_a, h_a);
          chk("mi_hold_b", mul_if.in_b, h_b);
          chk("mi_hold_op", 32'(mul_if.in_op), 32'(h_op));
        end
        if (wb_if.valid && wb_if.ready) begin
          n_wb++;
          last_data = wb_if.data;
          last_rd   = wb_if.rd;
          last_we   = wb_if.we;
          if (exp_q.size() == 0) begin
            chk("wb_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("wb_rd", 32'(wb_if.rd), 32'(e.rd));
            chk("wb_we", 32'(wb_if.we), 32'(e.we));
            chk("wb_data", wb_if.data, e.data);
          end
        end
        wb_held = wb_if.valid && !wb_if.ready;
        h_data  = wb_if.data;
        h_rdwe  = {wb_if.rd, wb_if.we};
        mi_held = mul_if.in_valid && !mul_if.in_ready;
        h_a     = mul_if.in_a;
        h_b     = mul_if.in_b;
        h_op    = mul_if.in_op;
      end
    end
  end

  // Presents one request, holds it until accepted, records its expected writeback.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    int  t = 0;
    bit  ok = 1'b0;
    @(negedge clk);
    req_if.valid  = 1'b1;
    req_if.funct3 = f3;
    req_if.rs1    = a;
    req_if.rs2    = b;
    req_if.rd     = rd;
    while (!ok && t < 200) begin
      #4;
      if (req_if.ready) ok = 1'b1;
      else begin t++; @(negedge clk); end
    end
    if (!ok) begin
      chk("req_timeout", 32'd0, 32'd1);
      req_if.valid = 1'b0;
    end else begin
      exp_q.push_back(rec_t'{rd: rd, we: (rd != 5'd0), data: ref_mul(int'(f3[1:0]), a, b)});
      n_acc++;
      @(posedge clk);
      #1 req_if.valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      #4;
      t++;
    end
    chk("drain", 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  task automatic one(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data);
    send(f3, a, b, rd);
    drain();
    chk({tag, "_data"}, last_data, exp_data);
    chk({tag, "_rd"}, 32'(last_rd), 32'(rd));
    chk({tag, "_we"}, 32'(last_we), 32'(rd != 5'd0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_valid"}, 32'(mul_if.in_valid), 32'd0);
    chk({tag, "_out_ready"}, 32'(mul_if.out_ready), 32'd1);
    chk({tag, "_wb_valid"}, 32'(wb_if.valid), 32'd0);
    chk({tag, "_wb_we"}, 32'(wb_if.we), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_if.rd), 32'd0);
    chk({tag, "_wb_data"}, wb_if.data, 32'd0);
    chk({tag, "_in_a"}, mul_if.in_a, 32'd0);
    chk({tag, "_in_b"}, mul_if.in_b, 32'd0);
    chk({tag, "_in_op"}, 32'(mul_if.in_op), 32'(MUL_NONE));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int iss0, wb0;
    req_if.valid  = 1'b0;
    req_if.funct3 = '0;
    req_if.rs1    = '0;
    req_if.rs2    = '0;
    req_if.rd     = '0;
    repeat (3) @(negedge clk);
    #4 chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    // Basic MUL with issue/writeback latency.
    iss0 = n_iss;
    send(3'd0, 32'd7, 32'd6, 5'd5);
    @(negedge clk); #4;
    chk("lat_issue", 32'(mul_if.in_valid), 32'd1);
    @(negedge clk); #4;
    chk("lat_wb_early", 32'(wb_if.valid), 32'd0);
    @(negedge clk); #4;
    chk("lat_wb", 32'(wb_if.valid), 32'd1);
    drain();
    chk("t1_data", last_data, 32'h0000_002A);
    chk("t1_rd", 32'(last_rd), 32'd5);
    chk("t1_we", 32'(last_we), 32'd1);
    chk("t1_op", 32'(last_op), 32'(MUL_MUL));
    chk("t1_issues", 32'(n_iss - iss0), 32'd1);

    one("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000);
    one("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE);
    one("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF);
    one("rd0", 3'd0, 32'd3, 32'd4, 5'd0, 32'h0000_000C);

    // Writeback stalled: tags fill, later requests back up, then drain in order.
    wb0     = n_wb;
    wb_mode = 0;
    send(3'd0, 32'd1, 32'd11, 5'd1);
    send(3'd0, 32'd2, 32'd11, 5'd2);
    send(3'd0, 32'd3, 32'd11, 5'd3);
    fork
      begin
        repeat (20) @(negedge clk);
        wb_mode = 1;
      end
      begin
        @(negedge clk);
        req_if.valid  = 1'b1;
        req_if.funct3 = 3'd0;
        req_if.rs1    = 32'd4;
        req_if.rs2    = 32'd11;
        req_if.rd     = 5'd4;
        #4;
        chk("full_ready", 32'(req_if.ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        chk("full_wb_vld", 32'(wb_if.valid), 32'd1);
        send(3'd0, 32'd4, 32'd11, 5'd4);
      end
    join
    drain();
    chk("stall_count", 32'(n_wb - wb0), 32'd4);
    chk("stall_last_rd", 32'(last_rd), 32'd4);
    chk("stall_last_data", last_data, 32'd44);

    // Reset with a request in flight.
    send(3'd0, 32'd5, 32'd5, 5'd3);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #4 chk_reset_vals("midrst");
    one("post_rst", 3'd0, 32'd2, 32'd2, 5'd1, 32'd4);

    // Zero operand on an idle block.
    iss0 = n_iss;
    send(3'd0, 32'd0, 32'h1234, 5'd9);
    @(negedge clk); #4;
`ifdef MUL_ZERO_BYPASS_EN
    chk("byp_wb_n1", 32'(wb_if.valid), 32'd1);
    chk("byp_no_issue", 32'(mul_if.in_valid), 32'd0);
`else
    chk("zero_wb_n1", 32'(wb_if.valid), 32'd0);
    chk("zero_issue", 32'(mul_if.in_valid), 32'd1);
`endif
    drain();
    chk("zero_data", last_data, 32'd0);
    chk("zero_rd", 32'(last_rd), 32'd9);
`ifdef MUL_ZERO_BYPASS_EN
    chk("zero_issues", 32'(n_iss - iss0), 32'd0);
`else
    chk("zero_issues", 32'(n_iss - iss0), 32'd1);
`endif

    // Zero operand behind a pending op must use the multiplier and stay in order.
    iss0        = n_iss;
    mul_max_dly = 3;
    send(3'd0, 32'd3, 32'd3, 5'd4);
    send(3'd0, 32'd0, 32'h1234, 5'd9);
    drain();
    chk("behind_issues", 32'(n_iss - iss0), 32'd2);
    chk("behind_last_rd", 32'(last_rd), 32'd9);

    // Random traffic with random back-pressure on both sides.
    mul_rdy_pct = 70;
    wb_mode     = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      send(3'($urandom_range(3)), pick_opnd(), pick_opnd(), 5'($urandom_range(31)));
    end
    wb_mode = 1;
    drain();
    chk("total_wb", 32'(n_wb), 32'(n_acc - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
